dpll_loop_filter: RTL and testbench

- Digital proportional-integral loop filter for the digital PLL.
- Sits between the bang-bang phase detector (up/dn decisions at the reference rate) and the DCO code input.
- Produces the 13-bit DCO control code.
- Includes a lock detector and an acquisition/tracking gear-shift FSM, so the loop pulls in fast and then settles with low jitter.

---
 rtl/dpll_pkg.sv | 46 ++++
 rtl/dpll_lock_det.sv | 80 ++++++++
 rtl/dpll_loop_filter.sv | 132 +++++++++++++
 tb/tb_dpll_loop_filter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/dpll_pkg.sv
// dpll_pkg: types and helpers shared by the digital PLL blocks.
// Loop-filter state, phase-detector sign decode and unsigned clamp.
package dpll_pkg;

    localparam int DPLL_WIDTH = 13;
    localparam int DPLL_FRAC  = 8;

    typedef enum logic {
        ACQ   = 1'b0,
        TRACK = 1'b1
    } lf_state_t;

    // up/dn decision as -1, 0 or +1
    function automatic logic signed [1:0] pd_sign(
        input logic up,
        input logic dn
    );
        logic signed [1:0] s;
        s = 2'sd0;
        if (up && !dn) begin
            s = 2'sd1;
        end else if (dn && !up) begin
            s = -2'sd1;
        end
        return s;
    endfunction

    // clamp a signed value into 0 .. 2^width-1
    function automatic logic [31:0] sat_u(
        input logic signed [31:0] value,
        input int                 width
    );
        logic signed [31:0] hi;
        logic [31:0]        r;
        hi = (32'sd1 <<< width) - 32'sd1;
        if (value < 32'sd0) begin
            r = 32'd0;
        end else if (value > hi) begin
            r = $unsigned(hi);
        end else begin
            r = $unsigned(value);
        end
        return r;
    endfunction

endpackage

// File: rtl/dpll_lock_det.sv
// dpll_lock_det: windowed sum of PD signs and quiet-window counter.
// Flags a window end, a quiet-run completion and a loud window.
module dpll_lock_det
    import dpll_pkg::*;
#(
    parameter int LOCK_WIN   = 32,
    parameter int LOCK_THR   = 4,
    parameter int LOCK_N     = 4,
    parameter int UNLOCK_THR = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              en_i,
    input  logic signed [1:0] sign_i,
    input  logic              acq_i,
    output logic              win_end_o,
    output logic              lock_go_o,
    output logic              loud_o
);

    localparam int CW = (LOCK_WIN > 1) ? $clog2(LOCK_WIN) : 1;
    localparam int SW = CW + 2;
    localparam int QW = $clog2(LOCK_N + 1);

    logic [CW-1:0]        cnt_q;
    logic [CW-1:0]        cnt_d;
    logic signed [SW-1:0] sum_q;
    logic signed [SW-1:0] sum_d;
    logic signed [SW-1:0] sum_fin;
    logic [SW-1:0]        sum_abs;
    logic [QW-1:0]        quiet_q;
    logic [QW-1:0]        quiet_d;
    logic                 quiet_win;

    // window bookkeeping; the closing sum includes this cycle's sign
    always_comb begin
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        quiet_d = quiet_q;
        sum_fin = sum_q + SW'(sign_i);
        if (sum_fin[SW-1]) begin
            sum_abs = $unsigned(-sum_fin);
        end else begin
            sum_abs = $unsigned(sum_fin);
        end
        win_end_o = en_i && (cnt_q == CW'(LOCK_WIN - 1));
        quiet_win = (sum_abs <= SW'(LOCK_THR));
        loud_o    = win_end_o && (sum_abs > SW'(UNLOCK_THR));
        lock_go_o = win_end_o && acq_i && quiet_win
                    && (quiet_q == QW'(LOCK_N - 1));
        if (en_i) begin
            if (win_end_o) begin
                cnt_d = '0;
                sum_d = '0;
                if (!acq_i || !quiet_win || lock_go_o) begin
                    quiet_d = '0;
                end else begin
                    quiet_d = quiet_q + QW'(1);
                end
            end else begin
                cnt_d = cnt_q + CW'(1);
                sum_d = sum_fin;
            end
        end
    end

    // detector state registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q   <= '0;
            sum_q   <= '0;
            quiet_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            quiet_q <= quiet_d;
        end
    end

endmodule

// File: rtl/dpll_loop_filter.sv
// dpll_loop_filter: PI loop filter from bang-bang PD to DCO code.
// Gear-shifts from ACQ to TRACK gains once the lock detector is quiet.
module dpll_loop_filter
    import dpll_pkg::*;
#(
    parameter int               WIDTH      = DPLL_WIDTH,
    parameter int               FRAC       = DPLL_FRAC,
    parameter logic [WIDTH-1:0] INIT_VALUE = 13'b1_0000_0000_0000,
    parameter int               KP_ACQ     = 4,
    parameter int               KI_ACQ     = 6,
    parameter int               KP_TRK     = 1,
    parameter int               KI_TRK     = 2,
    parameter int               LOCK_WIN   = 32,
    parameter int               LOCK_THR   = 4,
    parameter int               LOCK_N     = 4,
    parameter int               UNLOCK_THR = 16
) (
    input  logic             clk_ref,
    input  logic             reset,
    input  logic             up,
    input  logic             dn,
    input  logic             hold,
    output logic [WIDTH-1:0] code,
    output logic             locked,
    output logic [WIDTH-1:0] acc_int
);

    localparam int AW = WIDTH + FRAC;

    lf_state_t          state_q;
    lf_state_t          state_d;
    logic [AW-1:0]      acc_q;
    logic [AW-1:0]      acc_d;
    logic [WIDTH-1:0]   code_q;
    logic [WIDTH-1:0]   code_d;
    logic               locked_q;
    logic signed [1:0]  sign;
    int                 kp;
    int                 ki;
    logic signed [31:0] step_i;
    logic signed [31:0] step_p;
    logic signed [31:0] acc_ext;
    logic signed [31:0] acc_sum;
    logic signed [31:0] code_sum;
    logic [31:0]        acc_sat;
    logic [31:0]        code_sat;
    logic               win_end;
    logic               lock_go;
    logic               loud;
    logic               unused_ok;

    dpll_lock_det #(
        .LOCK_WIN   (LOCK_WIN),
        .LOCK_THR   (LOCK_THR),
        .LOCK_N     (LOCK_N),
        .UNLOCK_THR (UNLOCK_THR)
    ) u_lock_det (
        .clk_i     (clk_ref),
        .reset_i   (reset),
        .en_i      (!hold),
        .sign_i    (sign),
        .acq_i     (state_q == ACQ),
        .win_end_o (win_end),
        .lock_go_o (lock_go),
        .loud_o    (loud)
    );

    // integral then proportional path, each clamped in a wide signed sum
    always_comb begin
        sign    = pd_sign(up, dn);
        kp      = (state_q == TRACK) ? KP_TRK : KP_ACQ;
        ki      = (state_q == TRACK) ? KI_TRK : KI_ACQ;
        step_i  = 32'sd1 <<< ki;
        step_p  = 32'sd1 <<< kp;
        acc_ext = $signed(32'(acc_q));
        acc_sum = acc_ext;
        if (sign == 2'sd1) begin
            acc_sum = acc_ext + step_i;
        end else if (sign == -2'sd1) begin
            acc_sum = acc_ext - step_i;
        end
        acc_sat  = sat_u(acc_sum, AW);
        code_sum = $signed(32'(acc_sat[AW-1:FRAC]));
        if (sign == 2'sd1) begin
            code_sum = code_sum + step_p;
        end else if (sign == -2'sd1) begin
            code_sum = code_sum - step_p;
        end
        code_sat = sat_u(code_sum, WIDTH);
        if (hold) begin
            acc_d  = acc_q;
            code_d = acc_q[AW-1:FRAC];
        end else begin
            acc_d  = acc_sat[AW-1:0];
            code_d = code_sat[WIDTH-1:0];
        end
    end

    // gear-shift decision; detector strobes are already gated by hold
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ACQ: begin
                if (lock_go) state_d = TRACK;
            end
            TRACK: begin
                if (loud) state_d = ACQ;
            end
        endcase
    end

    // loop state, code and lock flag
    always_ff @(posedge clk_ref) begin
        if (reset) begin
            state_q  <= ACQ;
            acc_q    <= {INIT_VALUE, {FRAC{1'b0}}};
            code_q   <= INIT_VALUE;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            code_q   <= code_d;
            locked_q <= (state_d == TRACK);
        end
    end

    assign code      = code_q;
    assign locked    = locked_q;
    assign acc_int   = acc_q[AW-1:FRAC];
    assign unused_ok = ^{acc_sat[31:AW], code_sat[31:WIDTH], win_end};

endmodule

// File: tb/tb_dpll_loop_filter.sv
// tb_dpll_loop_filter: three filter instances (mid, low, high init)
// against an integer reference model, directed then random stimulus.
module tb_dpll_loop_filter;

    logic clk_ref = 1'b0;
    always #5 clk_ref = ~clk_ref;

    logic        rst_s  [3];
    logic        up_s   [3];
    logic        dn_s   [3];
    logic        hold_s [3];
    logic [12:0] code_s [3];
    logic [12:0] acc_s  [3];
    logic        lock_s [3];

    int n_chk = 0;
    int n_err = 0;

    int init_v [3] = '{4096, 10, 8190};
    int m_acc  [3];
    int m_code [3];
    int m_trk  [3];
    int m_cnt  [3];
    int m_sum  [3];
    int m_qt   [3];

    dpll_loop_filter u_mid (
        .clk_ref (clk_ref), .reset (rst_s[0]),
        .up (up_s[0]), .dn (dn_s[0]), .hold (hold_s[0]),
        .code (code_s[0]), .locked (lock_s[0]), .acc_int (acc_s[0])
    );

    dpll_loop_filter #(.INIT_VALUE(13'd10)) u_low (
        .clk_ref (clk_ref), .reset (rst_s[1]),
        .up (up_s[1]), .dn (dn_s[1]), .hold (hold_s[1]),
        .code (code_s[1]), .locked (lock_s[1]), .acc_int (acc_s[1])
    );

    dpll_loop_filter #(.INIT_VALUE(13'd8190)) u_high (
        .clk_ref (clk_ref), .reset (rst_s[2]),
        .up (up_s[2]), .dn (dn_s[2]), .hold (hold_s[2]),
        .code (code_s[2]), .locked (lock_s[2]), .acc_int (acc_s[2])
    );

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int clamp(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    // one reference-rate step of the behavioural loop filter
    task automatic m_step(input int k);
        int s;
        int a;
        if (rst_s[k]) begin
            m_acc[k]  = init_v[k] * 256;
            m_code[k] = init_v[k];
            m_trk[k]  = 0;
            m_cnt[k]  = 0;
            m_sum[k]  = 0;
            m_qt[k]   = 0;
            return;
        end
        s = (up_s[k] && !dn_s[k]) ? 1 : ((dn_s[k] && !up_s[k]) ? -1 : 0);
        if (hold_s[k]) begin
            m_code[k] = m_acc[k] / 256;
            return;
        end
        m_acc[k]  = clamp(m_acc[k] + s * (m_trk[k] ? 4 : 64), 2097151);
        m_code[k] = clamp(m_acc[k] / 256 + s * (m_trk[k] ? 2 : 16), 8191);
        m_sum[k]  = m_sum[k] + s;
        if (m_cnt[k] == 31) begin
            a = (m_sum[k] < 0) ? -m_sum[k] : m_sum[k];
            if (m_trk[k] == 0) begin
                m_qt[k] = (a <= 4) ? m_qt[k] + 1 : 0;
                if (m_qt[k] == 4) begin
                    m_trk[k] = 1;
                    m_qt[k]  = 0;
                end
            end else if (a > 16) begin
                m_trk[k] = 0;
                m_qt[k]  = 0;
            end
            m_cnt[k] = 0;
            m_sum[k] = 0;
        end else begin
            m_cnt[k] = m_cnt[k] + 1;
        end
    endtask

    task automatic drive(input int k, input bit r, input bit u,
                         input bit d, input bit h);
        rst_s[k]  = r;
        up_s[k]   = u;
        dn_s[k]   = d;
        hold_s[k] = h;
    endtask

    task automatic tick();
        @(posedge clk_ref);
        for (int k = 0; k < 3; k++) m_step(k);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("code[%0d]", k), int'(code_s[k]), m_code[k]);
            check($sformatf("acc_int[%0d]", k), int'(acc_s[k]), m_acc[k] / 256);
            check($sformatf("locked[%0d]", k), int'(lock_s[k]), m_trk[k]);
        end
    endtask

    initial begin
        int held;
        int mode [3];
        bit u;
        bit d;

        for (int k = 0; k < 3; k++) drive(k, 1, 0, 0, 0);
        tick();
        tick();
        check("rst_code0", int'(code_s[0]), 4096);
        check("rst_acc0", int'(acc_s[0]), 4096);
        check("rst_lock0", int'(lock_s[0]), 0);
        check("rst_code1", int'(code_s[1]), 10);
        check("rst_code2", int'(code_s[2]), 8190);

        drive(0, 0, 1, 0, 0);
        drive(1, 0, 0, 1, 0);
        drive(2, 0, 1, 0, 0);
        tick();
        check("acq1_code", int'(code_s[0]), 4112);
        check("acq1_acc", int'(acc_s[0]), 4096);
        check("low_code", int'(code_s[1]), 0);
        check("high_code", int'(code_s[2]), 8191);
        tick();
        tick();
        tick();
        check("acq4_code", int'(code_s[0]), 4113);
        check("acq4_acc", int'(acc_s[0]), 4097);

        drive(0, 1, 0, 0, 0);
        tick();
        check("rerst_code", int'(code_s[0]), 4096);
        for (int t = 1; t <= 160; t++) begin
            drive(0, 0, t[0], !t[0], 0);
            tick();
            check("low_hold0", int'(code_s[1]), 0);
            check("high_hold", int'(code_s[2]), 8191);
            if (t == 127) check("lock_pre", int'(lock_s[0]), 0);
            if (t == 128) check("lock_rise", int'(lock_s[0]), 1);
            if (t > 128) begin
                check("trk_step", int'(code_s[0]) - int'(acc_s[0]),
                      t[0] ? 2 : -2);
            end
        end
        check("low_clamp", int'(acc_s[1]), 0);
        check("high_clamp", int'(acc_s[2]), 8191);

        for (int t = 1; t <= 32; t++) begin
            drive(0, 0, 1, 0, 0);
            tick();
            if (t == 31) check("unlock_pre", int'(lock_s[0]), 1);
            if (t == 32) check("unlock_fall", int'(lock_s[0]), 0);
        end
        tick();
        check("acq_kp", int'(code_s[0]) - int'(acc_s[0]), 16);

        held = -1;
        for (int t = 0; t < 50; t++) begin
            drive(0, 0, 1, 0, 1);
            tick();
            if (held < 0) held = int'(code_s[0]);
            check("hold_code", int'(code_s[0]), int'(acc_s[0]));
            check("hold_const", int'(code_s[0]), held);
        end

        for (int b = 0; b < 6; b++) begin
            for (int k = 0; k < 3; k++) mode[k] = $urandom_range(0, 2);
            for (int t = 0; t < 160; t++) begin
                for (int k = 0; k < 3; k++) begin
                    if (mode[k] == 0) begin
                        u = t[0];
                        d = !t[0];
                        if ($urandom_range(0, 99) < 3) d = u;
                    end else if (mode[k] == 1) begin
                        u = 1'($urandom_range(0, 1));
                        d = 1'($urandom_range(0, 1));
                    end else begin
                        u = ($urandom_range(0, 99) < 75);
                        d = !u;
                    end
                    drive(k, ($urandom_range(0, 999) < 3), u, d,
                          ($urandom_range(0, 99) < 4));
                end
                tick();
            end
        end

        for (int t = 0; t < 5; t++) begin
            drive(0, 0, t[0], !t[0], 0);
            tick();
        end
        drive(0, 1, 1, 0, 1);
        tick();
        check("mid_rst_code", int'(code_s[0]), 4096);
        check("mid_rst_acc", int'(acc_s[0]), 4096);
        check("mid_rst_lock", int'(lock_s[0]), 0);
        drive(0, 0, 1, 0, 0);
        tick();
        check("post_rst_code", int'(code_s[0]), 4112);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
